// File: rtl/image_sobel_edge_if.sv
// Pixel stream bundle: frame sync, line sync, pixel strobe and 24-bit
// replicated-gray data. The producer drives through master, the consumer reads through slave.
interface image_sobel_edge_if;
  logic        vs;
  logic        hs;
  logic        valid;
  logic [23:0] data;

  modport master (output vs, hs, valid, data);
  modport slave  (input  vs, hs, valid, data);
endinterface

// File: rtl/image_sobel_edge.sv
// Sobel edge detector for a replicated-gray pixel stream. It uses two line
// buffers, a 3x3 window and a fixed 4-clock gradient/threshold pipeline.
module image_sobel_edge #(
  parameter int IMG_WIDTH = 640,
  parameter int OUT_MODE  = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [10:0]        threshold,
  image_sobel_edge_if.slave  in_if,
  image_sobel_edge_if.master out_if
);
  localparam int CW = $clog2(IMG_WIDTH + 1);
  localparam int AW = $clog2(IMG_WIDTH);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_WIDTH);

  logic          vs_q, valid_q;
  logic [CW-1:0] col_q, col_d;
  logic [1:0]    row_q, row_d;
  logic [10:0]   th_q, th_d;
  logic [3:0]    vs_dly_q, vs_dly_d, hs_dly_q, hs_dly_d, vld_dly_q, vld_dly_d;
  logic          vs_rise, line_end, in_range, rd_en;
  logic [AW-1:0] rd_addr;

  assign vs_rise  = in_if.vs & ~vs_q;
  assign line_end = valid_q & ~in_if.valid;
  assign in_range = (col_q < COL_MAX);
  assign rd_en    = in_if.valid & in_range;
  assign rd_addr  = col_q[AW-1:0];

  // A frame start overrides a line end that lands on the same clock.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    th_d  = th_q;
    if (vs_rise) begin
      col_d = '0;
      row_d = '0;
      th_d  = threshold;
    end else if (line_end) begin
      col_d = '0;
      if (row_q != 2'd3) row_d = row_q + 2'd1;
    end else if (in_if.valid && in_range) begin
      col_d = col_q + CW'(1);
    end
  end

  assign vs_dly_d  = {vs_dly_q[2:0], in_if.vs};
  assign hs_dly_d  = {hs_dly_q[2:0], in_if.hs};
  assign vld_dly_d = {vld_dly_q[2:0], in_if.valid};

  // Line buffers: lb0 is the previous line and lb1 is the line before that.
  // The read registers form the newest window column. lb1 takes the old lb0 word one clock later.
  logic [7:0]    lb0_mem [IMG_WIDTH];
  logic [7:0]    lb1_mem [IMG_WIDTH];
  logic [7:0]    top_rd_q, mid_rd_q;
  logic          lb1_we_q, lb1_we_d;
  logic [AW-1:0] lb1_wa_q, lb1_wa_d;

  assign lb1_we_d = rd_en;
  assign lb1_wa_d = rd_en ? rd_addr : lb1_wa_q;

  always_ff @(posedge clk) begin
    if (rd_en) begin
      top_rd_q         <= lb1_mem[rd_addr];
      mid_rd_q         <= lb0_mem[rd_addr];
      lb0_mem[rd_addr] <= in_if.data[7:0];
    end
    if (lb1_we_q) lb1_mem[lb1_wa_q] <= mid_rd_q;
  end

  logic [7:0]           bot_q, bot_d;
  logic [2:0][7:0]      col_new;
  logic [2:0][2:0][7:0] win;

  assign bot_d   = in_if.valid ? in_if.data[7:0] : bot_q;
  assign col_new = {bot_q, mid_rd_q, top_rd_q};

  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : g_row
    logic [7:0] c0_q, c0_d, c1_q, c1_d;

    always_comb begin
      c0_d = c0_q;
      c1_d = c1_q;
      if (in_if.valid) begin
        c0_d = c1_q;
        c1_d = col_new[gi];
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        c0_q <= '0;
        c1_q <= '0;
      end else begin
        c0_q <= c0_d;
        c1_q <= c1_d;
      end
    end

    assign win[gi] = {col_new[gi], c1_q, c0_q};
  end

  logic [7:0] p11, p12, p13, p21, p23, p31, p32, p33;
  assign p11 = win[0][0];
  assign p12 = win[0][1];
  assign p13 = win[0][2];
  assign p21 = win[1][0];
  assign p23 = win[1][2];
  assign p31 = win[2][0];
  assign p32 = win[2][1];
  assign p33 = win[2][2];

  logic [9:0]  gx_pos, gx_neg, gy_pos, gy_neg;
  logic [10:0] gx_q, gx_d, gy_q, gy_d, ax, ay, mag_q, mag_d;
  logic        bdr1_q, bdr1_d, bdr2_q, bdr2_d, bdr3_q, bdr3_d;
  logic [7:0]  edge_q, edge_d;

  assign gx_pos = 10'(p13) + {1'b0, p23, 1'b0} + 10'(p33);
  assign gx_neg = 10'(p11) + {1'b0, p21, 1'b0} + 10'(p31);
  assign gy_pos = 10'(p31) + {1'b0, p32, 1'b0} + 10'(p33);
  assign gy_neg = 10'(p11) + {1'b0, p12, 1'b0} + 10'(p13);

  assign gx_d = vld_dly_q[0] ? (11'(gx_pos) - 11'(gx_neg)) : gx_q;
  assign gy_d = vld_dly_q[0] ? (11'(gy_pos) - 11'(gy_neg)) : gy_q;
  assign ax   = gx_q[10] ? (~gx_q + 11'd1) : gx_q;
  assign ay   = gy_q[10] ? (~gy_q + 11'd1) : gy_q;
  assign mag_d = vld_dly_q[1] ? (ax + ay) : mag_q;

  // The border flag covers rows 0-1, columns 0-1 and pixels past the line width.
  assign bdr1_d = in_if.valid ? ((row_q < 2'd2) | (col_q < CW'(2)) | ~in_range) : bdr1_q;
  assign bdr2_d = vld_dly_q[0] ? bdr1_q : bdr2_q;
  assign bdr3_d = vld_dly_q[1] ? bdr2_q : bdr3_q;

  always_comb begin
    edge_d = edge_q;
    if (vld_dly_q[2]) begin
      if (bdr3_q)             edge_d = 8'h00;
      else if (OUT_MODE == 0) edge_d = (mag_q >= th_q) ? 8'hFF : 8'h00;
      else                    edge_d = (mag_q > 11'd255) ? 8'hFF : mag_q[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_q      <= 1'b0;
      valid_q   <= 1'b0;
      col_q     <= '0;
      row_q     <= '0;
      th_q      <= '0;
      vs_dly_q  <= '0;
      hs_dly_q  <= '0;
      vld_dly_q <= '0;
      lb1_we_q  <= 1'b0;
      lb1_wa_q  <= '0;
      bot_q     <= '0;
      gx_q      <= '0;
      gy_q      <= '0;
      mag_q     <= '0;
      bdr1_q    <= 1'b1;
      bdr2_q    <= 1'b1;
      bdr3_q    <= 1'b1;
      edge_q    <= '0;
    end else begin
      vs_q      <= in_if.vs;
      valid_q   <= in_if.valid;
      col_q     <= col_d;
      row_q     <= row_d;
      th_q      <= th_d;
      vs_dly_q  <= vs_dly_d;
      hs_dly_q  <= hs_dly_d;
      vld_dly_q <= vld_dly_d;
      lb1_we_q  <= lb1_we_d;
      lb1_wa_q  <= lb1_wa_d;
      bot_q     <= bot_d;
      gx_q      <= gx_d;
      gy_q      <= gy_d;
      mag_q     <= mag_d;
      bdr1_q    <= bdr1_d;
      bdr2_q    <= bdr2_d;
      bdr3_q    <= bdr3_d;
      edge_q    <= edge_d;
    end
  end

  assign out_if.vs    = vs_dly_q[3];
  assign out_if.hs    = hs_dly_q[3];
  assign out_if.valid = vld_dly_q[3];
  assign out_if.data  = {3{edge_q}};

  logic unused_bits;
  assign unused_bits = ^{in_if.data[23:8], win[1][1], th_q};
endmodule

// File: tb/tb_image_sobel_edge.sv
// Directed bench for image_sobel_edge: a binary-edge and a magnitude instance
// share one input stream and are checked against hand-derived expected pixels.
module tb_image_sobel_edge;
  localparam int W = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [10:0] threshold = '0;

  always #5 clk = ~clk;

  image_sobel_edge_if in_if ();
  image_sobel_edge_if out0_if ();
  image_sobel_edge_if out1_if ();

  image_sobel_edge #(.IMG_WIDTH(W), .OUT_MODE(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .threshold(threshold),
    .in_if(in_if), .out_if(out0_if)
  );
  image_sobel_edge #(.IMG_WIDTH(W), .OUT_MODE(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .threshold(threshold),
    .in_if(in_if), .out_if(out1_if)
  );

  int n_chk = 0;
  int n_err = 0;
  int q0[$];
  int q1[$];
  int last0 = 0;
  int last1 = 0;
  int cur_row = 0;
  int th_frame = 0;
  bit chk_en = 1'b0;
  logic [2:0] hist [5];

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rep3(input int v);
    logic [7:0] b;
    b = v[7:0];
    return int'({3{b}});
  endfunction

  // Columns 0-3 carry lo and 4-7 carry hi, so only windows ending at col 4 or 5 see G = 4*(hi-lo).
  function automatic void push_exp(input int r, input int c, input int lo, input int hi);
    int g, e0, e1;
    bit bdr;
    bdr = (r < 2) || (c < 2) || (c >= W);
    g = (c == 4 || c == 5) ? 4 * (hi - lo) : 0;
    if (bdr) begin
      e0 = 0;
      e1 = 0;
    end else begin
      e0 = (g >= th_frame) ? 255 : 0;
      e1 = (g > 255) ? 255 : g;
    end
    q0.push_back(e0);
    q1.push_back(e1);
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 4; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = {in_if.vs, in_if.hs, in_if.valid};
      check("dly0", int'({out0_if.vs, out0_if.hs, out0_if.valid}), int'(hist[4]));
      check("dly1", int'({out1_if.vs, out1_if.hs, out1_if.valid}), int'(hist[4]));
      if (out0_if.valid) begin
        if (q0.size() == 0) check("extra0", 1, 0);
        else begin
          last0 = q0.pop_front();
          check("pix0", int'(out0_if.data), rep3(last0));
        end
      end else check("hold0", int'(out0_if.data), rep3(last0));
      if (out1_if.valid) begin
        if (q1.size() == 0) check("extra1", 1, 0);
        else begin
          last1 = q1.pop_front();
          check("pix1", int'(out1_if.data), rep3(last1));
        end
      end else check("hold1", int'(out1_if.data), rep3(last1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_if.vs = 1'b0;
    in_if.hs = 1'b0;
    in_if.valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic vs_pulse();
    in_if.vs = 1'b1;
    in_if.valid = 1'b0;
    in_if.hs = 1'b0;
    cur_row = 0;
    th_frame = int'(threshold);
    tick();
    tick();
    in_if.vs = 1'b0;
    tick();
    tick();
  endtask

  task automatic drive_line(input int npix, input int lo, input int hi, input bit vs_end);
    for (int c = 0; c < npix; c++) begin
      in_if.vs = 1'b0;
      in_if.hs = 1'b1;
      in_if.valid = 1'b1;
      in_if.data = 24'(rep3((c < 4) ? lo : hi));
      push_exp(cur_row, c, lo, hi);
      tick();
    end
    in_if.valid = 1'b0;
    in_if.hs = 1'b0;
    if (vs_end) begin
      in_if.vs = 1'b1;
      cur_row = 0;
      th_frame = int'(threshold);
      tick();
      tick();
      in_if.vs = 1'b0;
    end else begin
      if (cur_row < 3) cur_row++;
      tick();
    end
    tick();
    tick();
  endtask

  initial begin
    in_if.vs = 1'b0;
    in_if.hs = 1'b0;
    in_if.valid = 1'b0;
    in_if.data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state0", int'({out0_if.vs, out0_if.hs, out0_if.valid, out0_if.data}), 0);
    check("rst_state1", int'({out1_if.vs, out1_if.hs, out1_if.valid, out1_if.data}), 0);
    reset_n = 1'b1;
    tick();
    tick();

    // Latency after reset: valid_o must rise on exactly the fourth clock.
    in_if.valid = 1'b1;
    in_if.hs = 1'b1;
    in_if.data = 24'(rep3(50));
    repeat (3) tick();
    check("lat3_valid0", int'(out0_if.valid), 0);
    check("lat3_valid1", int'(out1_if.valid), 0);
    tick();
    check("lat4_valid0", int'(out0_if.valid), 1);
    check("lat4_valid1", int'(out1_if.valid), 1);
    check("lat4_hs0", int'(out0_if.hs), 1);
    repeat (3) tick();

    // Asynchronous reset in the middle of a clock period while the stream runs.
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst0", int'({out0_if.vs, out0_if.hs, out0_if.valid, out0_if.data}), 0);
    check("async_rst1", int'({out1_if.vs, out1_if.hs, out1_if.valid, out1_if.data}), 0);
    in_if.valid = 1'b0;
    in_if.hs = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    idle(6);

    for (int i = 0; i < 5; i++) hist[i] = '0;
    last0 = 0;
    last1 = 0;
    chk_en = 1'b1;

    // Flat frame: no gradient anywhere.
    threshold = 11'd1;
    vs_pulse();
    for (int r = 0; r < 8; r++) drive_line(8, 100, 100, 1'b0);
    idle(4);

    // Step 0->200 at threshold 400; a mid-frame change to 1000 must not apply yet.
    threshold = 11'd400;
    vs_pulse();
    for (int r = 0; r < 3; r++) drive_line(8, 0, 200, 1'b0);
    threshold = 11'd1000;
    for (int r = 3; r < 8; r++) drive_line(8, 0, 200, 1'b0);
    idle(4);

    // New frame picks up threshold 1000: binary output drops, magnitude stays saturated.
    vs_pulse();
    for (int r = 0; r < 8; r++) drive_line(8, 0, 200, 1'b0);
    idle(4);

    // Small step 0->20 gives G = 80.
    threshold = 11'd50;
    vs_pulse();
    for (int r = 0; r < 8; r++) drive_line(8, 0, 20, 1'b0);
    idle(4);

    // Overlong line, then a vs rise on the same clock as a valid fall.
    threshold = 11'd400;
    vs_pulse();
    for (int r = 0; r < 3; r++) drive_line(8, 0, 200, 1'b0);
    drive_line(10, 0, 200, 1'b0);
    drive_line(8, 0, 200, 1'b0);
    drive_line(8, 0, 200, 1'b1);
    for (int r = 0; r < 4; r++) drive_line(8, 0, 200, 1'b0);
    idle(10);

    chk_en = 1'b0;
    check("drain0", q0.size(), 0);
    check("drain1", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/image_sobel_edge.md
Name: image_sobel_edge

Overview:
- Downstream consumer of the grayscale conversion stage: takes replicated-gray 24-bit pixels with vs/hs/valid and produces a Sobel edge map in the same 24-bit, vs/hs/valid format.
- Contains two line buffers, a 3x3 window, a Sobel gradient datapath and a threshold/saturate output stage.
- Sits between grayscale conversion and the display/storage path.

Parameters:
- IMG_WIDTH, 640, active pixels per line; sizes the line buffers and column counter.
- OUT_MODE, 0, output format: 0 = binary edge (255/0), 1 = gradient magnitude saturated to 255.

Ports:
- clk  input  1  pixel clock.
- reset_n  input  1  asynchronous, active-low reset.
- vs_in  input  1  frame sync, active high; rising edge marks frame start.
- hs_in  input  1  line sync; delayed only.
- valid_i  input  1  pixel strobe.
- img_data_i  input  24  gray pixel replicated; only [7:0] is used.
- threshold  input  11  edge threshold; sampled into th_q on the vs_in rising edge.
- vs_out  output  1  vs_in delayed 4 clocks.
- hs_out  output  1  hs_in delayed 4 clocks.
- valid_o  output  1  valid_i delayed 4 clocks.
- img_data_o  output  24  {3{edge_pix}}.

Behaviour:
- Reset (reset_n low, asynchronous): all outputs 0; delay lines, counters, window registers and th_q are 0. Line-buffer RAM contents are don't-care.
- Latency: fixed at 4 clocks from valid_i to valid_o, one output per input pixel. vs, hs and valid take identical 4-stage delays.
- Frame and line tracking:
  - col counts valid pixels within a line: 0..IMG_WIDTH-1.
  - A line ends on the clock where valid_i falls (valid_q=1, valid_i=0). On that clock col <= 0 and row increments, saturating at 3.
  - vs_in rising edge: row <= 0, col <= 0, th_q <= threshold.
  - If vs rise and valid fall occur on the same clock, the vs rise wins.
- Line buffers:
  - lb0 holds the previous line; lb1 holds the line before that. Each is IMG_WIDTH x 8.
  - On each valid pixel at col: read lb0[col] and lb1[col]; write lb1[col] <= lb0[col] and lb0[col] <= pixel.
  - Pixels with col >= IMG_WIDTH (overlong line) are not written, and their output is 0. col saturates at IMG_WIDTH.
- Window (stage 1): three 3-deep column shift registers, shifted only on valid pixels. Rows are top = lb1, mid = lb0, bottom = current pixel. p11..p33 are row-major; p33 is the newest pixel.
- Gradient (stage 2): Gx = (p13 + 2*p23 + p33) - (p11 + 2*p21 + p31); Gy = (p31 + 2*p32 + p33) - (p11 + 2*p12 + p13). Both are signed 11-bit; no overflow is possible.
- Magnitude (stage 3): G = |Gx| + |Gy|, unsigned 11-bit, maximum 2040.
- Output (stage 4):
  - OUT_MODE 0: edge_pix = (G >= th_q) ? 255 : 0.
  - OUT_MODE 1: edge_pix = (G > 255) ? 255 : G[7:0].
- Border:
  - When the window lacks full support (row < 2 or col < 2 at the pixel's input time), edge_pix = 0 regardless of mode.
  - The border flag travels with the pixel through the pipeline.
  - The output is the window centred on (row-1, col-1), so the edge map is offset by one line and one column.
- Non-valid cycles: the datapath and window registers hold their values. img_data_o holds its last value while valid_o = 0.
- Reset mid-frame: on release, row = 0 until the first line ends, so the first two lines after reset output 0. Normal output resumes on the next full frame.

Test Plan:
- Reset: hold reset_n low mid-stream with vs/hs/valid toggling -> all outputs 0 immediately (asynchronous); after release, valid_o first asserts 4 clocks after valid_i.
- Flat frame: 8x8 image, IMG_WIDTH=8, all pixels 100, threshold=1, OUT_MODE 0 -> all 64 outputs 0; vs_out/hs_out/valid_o equal the inputs delayed by exactly 4 clocks.
- Vertical step: 8x8 image, columns 0-3 = 0 and columns 4-7 = 200, threshold=400, OUT_MODE 0 -> 255 only where the window straddles the step (G = 800); 0 elsewhere and on rows 0-1 and cols 0-1.
- Magnitude mode: same step image with OUT_MODE 1 -> step outputs 255 (saturated). A step of 0 -> 20 gives G = 80, so output 80.
- Threshold sampling: change threshold from 400 to 1000 mid-frame -> the current frame still uses 400. The next frame (after a vs rise) uses 1000, and the step outputs become 0.
- Overlong line and simultaneous events: feed 10 valid pixels with IMG_WIDTH=8 -> pixels 9-10 output 0 and the next line is unaffected. A vs rise coinciding with a valid fall -> row = 0 (vs wins).
